// File: rtl/operand_entry.sv
// operand_entry: three-button entry of two 4-bit operands for Suma_Display.
//
// Each raw pushbutton is synchronized (two flops), debounced by a four-state
// FSM with a hold counter, and reduced to a one-cycle press event on the
// debounced rising edge. Events edit the selected operand (inc/dec, mod 16)
// or toggle which operand is selected.
//
// Ports:
//   clk      in   system clock, rising-edge
//   rst      in   asynchronous active-high reset
//   btn_inc  in   raw button: increment selected operand
//   btn_dec  in   raw button: decrement selected operand
//   btn_sel  in   raw button: toggle edit target
//   A        out  operand A (registered)
//   B        out  operand B (registered)
//   sel      out  edit target, 0 = A, 1 = B (registered)
//   upd      out  one-cycle pulse in the first cycle a new A/B/sel is visible
module operand_entry #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter logic [3:0]  A_INIT     = 4'd0,
  parameter logic [3:0]  B_INIT     = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_sel,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       sel,
  output logic       upd
);

  localparam int unsigned NumBtn = 3;
  // The counter never holds DEB_CYCLES itself: the state flips on the edge it
  // would get there, so DEB_CYCLES-1 is the largest stored value.
  localparam int unsigned    CntW    = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } deb_state_e;

  // Bit order for all per-button vectors: 0 = inc, 1 = dec, 2 = sel.
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;

  deb_state_e        st_q  [NumBtn];
  deb_state_e        st_d  [NumBtn];
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [CntW-1:0]   cnt_d [NumBtn];

  logic [NumBtn-1:0] deb;
  logic [NumBtn-1:0] deb_prev_q;
  logic [NumBtn-1:0] press;

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       sel_q, sel_d;
  logic       upd_q, upd_d;
  logic       arith;
  logic [3:0] delta;

  assign btn_raw = {btn_sel, btn_dec, btn_inc};

  // Two-flop synchronizers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumBtn; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
      deb_prev_q <= '0;
    end else begin
      for (int i = 0; i < NumBtn; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      deb_prev_q <= deb;
    end
  end

  // Debouncer next state. The counter holds the number of consecutive cycles
  // the synchronized level has disagreed with the debounced state; a single
  // agreeing cycle abandons the wait.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        StIdle: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) begin
            st_d[i]  = StPressWait;
            cnt_d[i] = CntOne;
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            st_d[i]  = StHeld;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StHeld: begin
          cnt_d[i] = '0;
          if (!sync2_q[i]) begin
            st_d[i]  = StReleaseWait;
            cnt_d[i] = CntOne;
          end
        end
        StReleaseWait: begin
          if (sync2_q[i]) begin
            st_d[i]  = StHeld;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CntLast) begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          st_d[i]  = StIdle;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      deb[i] = (st_q[i] == StHeld) || (st_q[i] == StReleaseWait);
    end
  end

  // Press event: debounced 0->1 only, so held buttons never repeat.
  assign press = deb & ~deb_prev_q;

  // Operand update. inc and dec together cancel; sel still toggles, and the
  // arithmetic targets the operand selected before the toggle.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sel_d = sel_q;
    arith = press[0] ^ press[1];
    delta = press[0] ? 4'd1 : 4'd15;
    if (arith) begin
      if (sel_q) begin
        b_d = b_q + delta;
      end else begin
        a_d = a_q + delta;
      end
    end
    if (press[2]) begin
      sel_d = ~sel_q;
    end
    upd_d = arith | press[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= A_INIT;
      b_q   <= B_INIT;
      sel_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sel_q <= sel_d;
      upd_q <= upd_d;
    end
  end

  assign A   = a_q;
  assign B   = b_q;
  assign sel = sel_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_operand_entry.sv
// Testbench for operand_entry with DEB_CYCLES=4. A behavioural model predicts
// outputs from the raw button history: a debounced level flips once the last
// DEB_CYCLES synchronized samples all disagree with it, and a rise becomes
// visible on the outputs one edge later.
module tb_operand_entry;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_sel = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic       sel;
  logic       upd;

  int checks = 0;
  int errors = 0;

  operand_entry #(
    .DEB_CYCLES (DEB),
    .A_INIT     (4'd0),
    .B_INIT     (4'd0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .btn_sel (btn_sel),
    .A       (A),
    .B       (B),
    .sel     (sel),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model. Button index 0 = inc, 1 = dec, 2 = sel.
  logic       m_hist [3][$];
  logic       m_deb  [3];
  logic       m_pend [3];
  logic [3:0] m_op   [2];
  logic       m_sel;
  logic       m_upd;

  function automatic logic hsample(int b, int idx);
    if (idx < 0) return 1'b0;
    return m_hist[b][idx];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_hist[b].delete();
      m_deb[b]  = 1'b0;
      m_pend[b] = 1'b0;
    end
    m_op[0] = 4'd0;
    m_op[1] = 4'd0;
    m_sel   = 1'b0;
    m_upd   = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic arith;
    logic flip;
    int   n;
    arith = m_pend[0] ^ m_pend[1];
    m_upd = arith | m_pend[2];
    if (arith) m_op[m_sel] = m_op[m_sel] + (m_pend[0] ? 4'd1 : 4'd15);
    if (m_pend[2]) m_sel = ~m_sel;
    for (int b = 0; b < 3; b++) begin
      m_pend[b] = 1'b0;
      m_hist[b].push_back(raw[b]);
      n    = m_hist[b].size();
      flip = 1'b1;
      // Sample sensed at this edge's synchronizer output was taken two edges ago.
      for (int j = n - int'(DEB) - 2; j <= n - 3; j++) begin
        if (hsample(b, j) == m_deb[b]) flip = 1'b0;
      end
      if (flip) begin
        m_deb[b]  = ~m_deb[b];
        m_pend[b] = m_deb[b];
      end
    end
  endtask

  // Drive at the falling edge, advance one rising edge, return at the next fall.
  task automatic step(input logic i, input logic d, input logic s);
    btn_inc = i;
    btn_dec = d;
    btn_sel = s;
    @(posedge clk);
    model_edge({s, d, i});
    @(negedge clk);
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic full_reset();
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    btn_sel = 1'b0;
    reset_assert();
    reset_release();
  endtask

  // One clean press-and-release; reports how many cycles upd was seen high.
  task automatic press(input logic [2:0] m, output int nupd);
    nupd = 0;
    repeat (DEB + 4) begin
      step(m[0], m[1], m[2]);
      if (upd === 1'b1) nupd++;
    end
    repeat (DEB + 4) begin
      step(1'b0, 1'b0, 1'b0);
      if (upd === 1'b1) nupd++;
    end
  endtask

  task automatic test_reset();
    btn_inc = 1'b1;
    reset_assert();
    checks++; if (A !== 4'd0)   begin errors++; $display("FAIL reset_A got %0d exp 0", A); end
    checks++; if (B !== 4'd0)   begin errors++; $display("FAIL reset_B got %0d exp 0", B); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", sel); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b exp 0", upd); end
    @(negedge clk);
    checks++; if (A !== 4'd0)   begin errors++; $display("FAIL reset_hold_A got %0d exp 0", A); end
    btn_inc = 1'b0;
    reset_release();
  endtask

  task automatic test_hold();
    full_reset();
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if ({A, B, sel, upd} !== {m_op[0], m_op[1], m_sel, m_upd}) begin
        errors++;
        $display("FAIL hold_model edge %0d got A=%0d B=%0d sel=%b upd=%b exp A=%0d B=%0d sel=%b upd=%b",
                 n, A, B, sel, upd, m_op[0], m_op[1], m_sel, m_upd);
      end
      checks++;
      if (n == 7) begin
        if (A !== 4'd1 || upd !== 1'b1) begin
          errors++;
          $display("FAIL hold_edge7 got A=%0d upd=%b exp A=1 upd=1", A, upd);
        end
      end else if (upd !== 1'b0 || A !== (n < 7 ? 4'd0 : 4'd1)) begin
        errors++;
        $display("FAIL hold_edge%0d got A=%0d upd=%b exp A=%0d upd=0", n, A, upd,
                 (n < 7 ? 0 : 1));
      end
    end
    checks++; if (B !== 4'd0) begin errors++; $display("FAIL hold_B got %0d exp 0", B); end
    repeat (10) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    full_reset();
    repeat (5) begin
      for (int k = 0; k < 6; k++) begin
        step(k < 3, 1'b0, 1'b0);
        checks++;
        if ({A, B, sel, upd} !== 10'd0) begin
          errors++;
          $display("FAIL glitch got A=%0d B=%0d sel=%b upd=%b exp all 0", A, B, sel, upd);
        end
      end
    end
    repeat (8) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (upd !== 1'b0 || A !== 4'd0) begin
        errors++;
        $display("FAIL glitch_tail got A=%0d upd=%b exp A=0 upd=0", A, upd);
      end
    end
  endtask

  task automatic test_wrap();
    int nupd;
    full_reset();
    repeat (15) press(3'b001, nupd);
    checks++; if (A !== 4'd15) begin errors++; $display("FAIL wrap_pre got A=%0d exp 15", A); end
    press(3'b001, nupd);
    checks++; if (A !== 4'd0) begin errors++; $display("FAIL wrap_inc got A=%0d exp 0", A); end
    checks++; if (nupd != 1) begin errors++; $display("FAIL wrap_upd got %0d pulses exp 1", nupd); end
    press(3'b010, nupd);
    checks++; if (A !== 4'd15) begin errors++; $display("FAIL wrap_dec got A=%0d exp 15", A); end
    checks++; if (nupd != 1) begin errors++; $display("FAIL wrap_dec_upd got %0d pulses exp 1", nupd); end
  endtask

  task automatic test_sel_dec();
    int nupd;
    full_reset();
    press(3'b100, nupd);
    checks++; if (sel !== 1'b1 || nupd != 1) begin
      errors++; $display("FAIL sel_toggle got sel=%b pulses=%0d exp sel=1 pulses=1", sel, nupd);
    end
    press(3'b010, nupd);
    checks++; if (B !== 4'd15 || A !== 4'd0) begin
      errors++; $display("FAIL sel_dec1 got A=%0d B=%0d exp A=0 B=15", A, B);
    end
    press(3'b010, nupd);
    checks++; if (B !== 4'd14 || A !== 4'd0) begin
      errors++; $display("FAIL sel_dec2 got A=%0d B=%0d exp A=0 B=14", A, B);
    end
    press(3'b011, nupd);
    checks++; if (B !== 4'd14 || A !== 4'd0 || sel !== 1'b1 || nupd != 0) begin
      errors++; $display("FAIL inc_dec_cancel got A=%0d B=%0d sel=%b pulses=%0d exp A=0 B=14 sel=1 pulses=0",
                         A, B, sel, nupd);
    end
  endtask

  task automatic test_sel_inc();
    int nupd;
    full_reset();
    repeat (3) press(3'b001, nupd);
    checks++; if (A !== 4'd3) begin errors++; $display("FAIL sel_inc_pre got A=%0d exp 3", A); end
    press(3'b101, nupd);
    checks++; if (A !== 4'd4 || sel !== 1'b1 || B !== 4'd0 || nupd != 1) begin
      errors++; $display("FAIL sel_inc got A=%0d B=%0d sel=%b pulses=%0d exp A=4 B=0 sel=1 pulses=1",
                         A, B, sel, nupd);
    end
  endtask

  task automatic test_reset_mid();
    int nupd;
    full_reset();
    repeat (5) press(3'b001, nupd);
    checks++; if (A !== 4'd5) begin errors++; $display("FAIL mid_pre got A=%0d exp 5", A); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    reset_assert();
    checks++; if (A !== 4'd0 || upd !== 1'b0) begin
      errors++; $display("FAIL mid_reset got A=%0d upd=%b exp A=0 upd=0", A, upd);
    end
    reset_release();
    for (int n = 1; n <= 12; n++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if ({A, B, sel, upd} !== {m_op[0], m_op[1], m_sel, m_upd}) begin
        errors++;
        $display("FAIL mid_model edge %0d got A=%0d upd=%b exp A=%0d upd=%b",
                 n, A, upd, m_op[0], m_upd);
      end
      if (n == 6 || n == 7) begin
        checks++;
        if (A !== (n == 7 ? 4'd1 : 4'd0) || upd !== (n == 7)) begin
          errors++;
          $display("FAIL mid_edge%0d got A=%0d upd=%b exp A=%0d upd=%b", n, A, upd,
                   (n == 7 ? 1 : 0), (n == 7));
        end
      end
    end
    repeat (10) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] lvl;
    int         run [3];
    full_reset();
    lvl = 3'b000;
    for (int b = 0; b < 3; b++) run[b] = $urandom_range(1, 9);
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          lvl[b] = ~lvl[b];
          run[b] = $urandom_range(1, 9);
        end
        run[b]--;
      end
      step(lvl[0], lvl[1], lvl[2]);
      checks++;
      if ({A, B, sel, upd} !== {m_op[0], m_op[1], m_sel, m_upd}) begin
        errors++;
        $display("FAIL random cyc %0d got A=%0d B=%0d sel=%b upd=%b exp A=%0d B=%0d sel=%b upd=%b",
                 n, A, B, sel, upd, m_op[0], m_op[1], m_sel, m_upd);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_hold();
    test_glitch();
    test_wrap();
    test_sel_dec();
    test_sel_inc();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
